vlc_demod_packer: RTL

- Receive-path stage between the 64-point forward FFT and axi_vlcrx_control.
- Consumes FFT output bins over AXI4-Stream and makes hard-decision demapping decisions on the 32 data subcarriers for BPSK, QPSK or 16-QAM.
- Packs the decided bits into 32-bit words and streams them downstream, asserting tlast on the last word of each OFDM symbol.
- Per-symbol word count is 1 for BPSK, 2 for QPSK and 4 for 16-QAM, matching the data registers and done logic of the receive controller.

---
 rtl/vlc_demod_packer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/vlc_demod_packer.sv
// Hard-decision BPSK/QPSK/16-QAM demapper for the 32 data bins of a 64-pt FFT,
// packing decided bits LSB-first into 32-bit AXI4-Stream words per OFDM symbol.
module vlc_demod_packer #(
    parameter int DW         = 24,
    parameter int DATA_START = 1,
    parameter int QAM_THR    = 4096
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic [1:0]      demod_type,
    input  logic [2*DW-1:0] s_axis_tdata,
    input  logic            s_axis_tvalid,
    input  logic            s_axis_tlast,
    output logic            s_axis_tready,
    output logic [31:0]     m_axis_tdata,
    output logic            m_axis_tvalid,
    output logic            m_axis_tlast,
    input  logic            m_axis_tready,
    output logic            frame_err
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic signed [DW-1:0] THR_P = DW'(QAM_THR);
    localparam logic signed [DW-1:0] THR_N = -THR_P;

    state_t state, state_nx;

    logic [1:0]  mode;
    logic [1:0]  mode_eff;
    logic [5:0]  bin;
    logic [4:0]  k;
    logic [31:0] acc;
    logic [31:0] acc_nx;
    logic [4:0]  pos;
    logic [5:0]  pos_sum;
    logic        accept;
    logic        is_data;
    logic        last_bin;
    logic        early_last;
    logic        word_done;

    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic        re_neg, re_big, im_neg, im_big;
    logic [3:0]  bits;
    logic [2:0]  nbits;

    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;

    assign re = s_axis_tdata[DW-1:0];
    assign im = s_axis_tdata[2*DW-1:DW];

    assign re_neg = re < 0;
    assign im_neg = im < 0;
    assign re_big = (re > THR_P) || (re < THR_N);
    assign im_big = (im > THR_P) || (im < THR_N);

    assign is_data = ({1'b0, bin} >= 7'(DATA_START)) &&
                     ({1'b0, bin} <  7'(DATA_START + 32));
    assign k          = 5'(bin - 6'(DATA_START));
    assign last_bin   = bin == 6'd63;
    assign early_last = s_axis_tlast && !last_bin;

    // Bin 0 is decoded with the mode being latched on that same beat
    assign mode_eff = (state == S_IDLE) ? demod_type : mode;

    always_comb begin
        bits  = 4'b0;
        nbits = 3'd4;
        unique case (mode_eff)
            2'd0: begin
                bits  = {3'b0, re_neg};
                nbits = 3'd1;
            end
            2'd1: begin
                bits  = {2'b0, im_neg, re_neg};
                nbits = 3'd2;
            end
            default: begin
                bits  = {im_big, im_neg, re_big, re_neg};
                nbits = 3'd4;
            end
        endcase
    end

    assign acc_nx    = acc | ({28'b0, bits} << pos);
    assign pos_sum   = {1'b0, pos} + {3'b0, nbits};
    assign word_done = is_data && (pos_sum == 6'd32);

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (accept && !s_axis_tlast) state_nx = S_RUN;
            S_RUN:  if (accept && (last_bin || s_axis_tlast)) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state         <= S_IDLE;
            mode          <= 2'd0;
            bin           <= 6'd0;
            acc           <= 32'd0;
            pos           <= 5'd0;
            frame_err     <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= 32'd0;
        end else begin
            state     <= state_nx;
            frame_err <= accept && (s_axis_tlast != last_bin);

            if (accept) begin
                if (state == S_IDLE) mode <= demod_type;
                bin <= early_last ? 6'd0 : bin + 6'd1;
                // Symbol end or misalignment drops any partially filled word
                if (early_last || last_bin) begin
                    acc <= 32'd0;
                    pos <= 5'd0;
                end else if (is_data) begin
                    acc <= word_done ? 32'd0 : acc_nx;
                    pos <= pos_sum[4:0];
                end
            end

            if (accept && word_done) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= acc_nx;
                m_axis_tlast  <= k == 5'd31;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule
